// File: rtl/trainer_pkg.sv
// Shared types and helpers for the activation trainer: FSM states,
// default widths and the exact target-minus-result error function.
package trainer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARG,
        RES,
        ERR,
        FBK,
        OUT
    } state_t;

    localparam int DEF_ARGW = 16;
    localparam int DEF_ARGN = 1;
    localparam int DEF_RESW = 8;
    localparam int DEF_ERRW = 16;

    // One extra bit keeps the difference of two unsigned results exact.
    function automatic logic signed [DEF_ERRW-1:0] delta(
        input logic [DEF_RESW-1:0] tgt,
        input logic [DEF_RESW-1:0] res
    );
        logic signed [DEF_RESW:0] d;
        d = $signed({1'b0, tgt}) - $signed({1'b0, res});
        return DEF_ERRW'(d);
    endfunction

endpackage

// File: rtl/activation_trainer.sv
// Drives one training sample through an activation unit: forward request,
// result capture, optional backward error/feedback, then one upstream beat.
module activation_trainer
    import trainer_pkg::*;
#(
    parameter int ARGW = DEF_ARGW,
    parameter int ARGN = DEF_ARGN,
    parameter int RESW = DEF_RESW,
    parameter int ERRW = DEF_ERRW,
    parameter int FBKW = ARGW * ARGN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 smp_stb,
    output logic                 smp_ack,
    input  logic [ARGW*ARGN-1:0] smp_arg,
    input  logic [RESW-1:0]      smp_tgt,
    output logic                 arg_stb,
    input  logic                 arg_ack,
    output logic [ARGW*ARGN-1:0] arg_dat,
    input  logic                 res_stb,
    output logic                 res_ack,
    input  logic [RESW-1:0]      res_dat,
    output logic                 err_stb,
    input  logic                 err_ack,
    output logic [ERRW-1:0]      err_dat,
    input  logic                 fbk_stb,
    output logic                 fbk_ack,
    input  logic [FBKW-1:0]      fbk_dat,
    output logic                 out_stb,
    input  logic                 out_ack,
    output logic [RESW-1:0]      out_res,
    output logic [FBKW-1:0]      out_fbk
);

    state_t state, nxt;

    logic [RESW-1:0]        tgt_q;
    logic                   en_q;
    logic signed [RESW:0]   diff;

    logic smp_xfer, arg_xfer, res_xfer, err_xfer, fbk_xfer, out_xfer;

    assign smp_xfer = smp_stb & smp_ack;
    assign arg_xfer = arg_stb & arg_ack;
    assign res_xfer = res_stb & res_ack;
    assign err_xfer = err_stb & err_ack;
    assign fbk_xfer = fbk_stb & fbk_ack;
    assign out_xfer = out_stb & out_ack;

    assign diff = $signed({1'b0, tgt_q}) - $signed({1'b0, res_dat});

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (smp_xfer) nxt = ARG;
            ARG:     if (arg_xfer) nxt = RES;
            RES:     if (res_xfer) nxt = en_q ? ERR : OUT;
            ERR:     if (err_xfer) nxt = FBK;
            FBK:     if (fbk_xfer) nxt = OUT;
            OUT:     if (out_xfer) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state and registered, so
    // smp_ack only rises on the first edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            smp_ack <= 1'b0;
            arg_stb <= 1'b0;
            res_ack <= 1'b0;
            err_stb <= 1'b0;
            fbk_ack <= 1'b0;
            out_stb <= 1'b0;
        end else begin
            state   <= nxt;
            smp_ack <= (nxt == IDLE);
            arg_stb <= (nxt == ARG);
            res_ack <= (nxt == RES);
            err_stb <= (nxt == ERR);
            fbk_ack <= (nxt == FBK);
            out_stb <= (nxt == OUT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arg_dat <= '0;
            tgt_q   <= '0;
            en_q    <= 1'b0;
            err_dat <= '0;
            out_res <= '0;
            out_fbk <= '0;
        end else begin
            if (smp_xfer) begin
                arg_dat <= smp_arg;
                tgt_q   <= smp_tgt;
                en_q    <= en;
            end
            if (res_xfer) begin
                out_res <= res_dat;
                if (en_q) begin
                    err_dat <= ERRW'(diff);
                end else begin
                    out_fbk <= '0;
                end
            end
            if (fbk_xfer) begin
                out_fbk <= fbk_dat;
            end
        end
    end

endmodule

// File: tb/tb_activation_trainer.sv
// Directed and randomized bench for activation_trainer with a behavioural
// activation responder driven inline from a single stimulus process.
module tb_activation_trainer;

    localparam int LIM = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        smp_stb;
    logic        smp_ack;
    logic [15:0] smp_arg;
    logic [7:0]  smp_tgt;
    logic        arg_stb;
    logic        arg_ack;
    logic [15:0] arg_dat;
    logic        res_stb;
    logic        res_ack;
    logic [7:0]  res_dat;
    logic        err_stb;
    logic        err_ack;
    logic [15:0] err_dat;
    logic        fbk_stb;
    logic        fbk_ack;
    logic [15:0] fbk_dat;
    logic        out_stb;
    logic        out_ack;
    logic [7:0]  out_res;
    logic [15:0] out_fbk;

    int total = 0;
    int bad = 0;
    logic [7:0] respRes;

    always #5 clk = ~clk;

    activation_trainer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .smp_stb (smp_stb),
        .smp_ack (smp_ack),
        .smp_arg (smp_arg),
        .smp_tgt (smp_tgt),
        .arg_stb (arg_stb),
        .arg_ack (arg_ack),
        .arg_dat (arg_dat),
        .res_stb (res_stb),
        .res_ack (res_ack),
        .res_dat (res_dat),
        .err_stb (err_stb),
        .err_ack (err_ack),
        .err_dat (err_dat),
        .fbk_stb (fbk_stb),
        .fbk_ack (fbk_ack),
        .fbk_dat (fbk_dat),
        .out_stb (out_stb),
        .out_ack (out_ack),
        .out_res (out_res),
        .out_fbk (out_fbk)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hard sigmoid stand-in: midpoint 0x80 at zero, clamped to the result range.
    function automatic logic [7:0] sigmoidModel(input logic [15:0] a);
        int r;
        r = 128 + ($signed(a) / 64);
        if (r > 255) r = 255;
        if (r < 0) r = 0;
        return 8'(r);
    endfunction

    task automatic applyStimulus(input logic [15:0] arg, input logic [7:0] tgt, input bit e,
                                 input int argDly, input int outDly, input bit sigm);
        int cnt;
        int edges;
        int d;
        logic [7:0]  resv;
        logic [15:0] expErr;
        logic [15:0] expFbk;
        resv   = sigm ? sigmoidModel(arg) : respRes;
        d      = int'(tgt) - int'(resv);
        expErr = 16'(d);
        expFbk = e ? 16'(d >>> 2) : 16'h0000;

        @(negedge clk);
        smp_stb = 1'b1;
        smp_arg = arg;
        smp_tgt = tgt;
        en      = e;
        cnt = 0;
        while (!smp_ack && cnt < LIM) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("smp_ack", 32'(smp_ack), 32'd1);
        @(posedge clk);
        edges = 0;
        @(negedge clk);
        smp_stb = 1'b0;
        smp_arg = 16'($urandom);
        smp_tgt = 8'($urandom);
        en      = ~e;
        checkOutput("smp_ack_busy", 32'(smp_ack), 32'd0);
        checkOutput("arg_stb", 32'(arg_stb), 32'd1);
        checkOutput("arg_dat", 32'(arg_dat), 32'(arg));

        for (int i = 0; i < argDly; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            checkOutput("arg_hold", 32'({arg_stb, smp_ack, arg_dat}), 32'({1'b1, 1'b0, arg}));
        end
        arg_ack = 1'b1;
        @(posedge clk);
        edges++;
        @(negedge clk);
        arg_ack = 1'b0;

        res_stb = 1'b1;
        res_dat = resv;
        cnt = 0;
        while (!res_ack && cnt < LIM) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("res_ack", 32'(res_ack), 32'd1);
        @(posedge clk);
        edges++;
        @(negedge clk);
        res_stb = 1'b0;
        res_dat = 8'($urandom);

        if (e) begin
            checkOutput("err_stb", 32'(err_stb), 32'd1);
            checkOutput("err_dat", 32'(err_dat), 32'(expErr));
            err_ack = 1'b1;
            @(posedge clk);
            edges++;
            @(negedge clk);
            err_ack = 1'b0;
            fbk_stb = 1'b1;
            fbk_dat = 16'($signed(err_dat) >>> 2);
            cnt = 0;
            while (!fbk_ack && cnt < LIM) begin
                @(negedge clk);
                cnt++;
            end
            checkOutput("fbk_ack", 32'(fbk_ack), 32'd1);
            @(posedge clk);
            edges++;
            @(negedge clk);
            fbk_stb = 1'b0;
            fbk_dat = 16'($urandom);
        end else begin
            checkOutput("err_stb_quiet", 32'(err_stb), 32'd0);
        end

        checkOutput("out_stb", 32'(out_stb), 32'd1);
        checkOutput("latency", 32'(edges), 32'((e ? 4 : 2) + argDly));
        checkOutput("out_res", 32'(out_res), 32'(resv));
        checkOutput("out_fbk", 32'(out_fbk), 32'(expFbk));
        for (int i = 0; i < outDly; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("out_hold", 32'({out_stb, smp_ack, out_res, out_fbk}),
                        32'({1'b1, 1'b0, resv, expFbk}));
        end
        out_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ack = 1'b0;
        checkOutput("out_done", 32'({out_stb, smp_ack}), 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        smp_stb = 1'b0;
        smp_arg = '0;
        smp_tgt = '0;
        arg_ack = 1'b0;
        res_stb = 1'b0;
        res_dat = '0;
        err_ack = 1'b0;
        fbk_stb = 1'b0;
        fbk_dat = '0;
        out_ack = 1'b0;
        respRes = 8'h00;

        #22;
        checkOutput("reset_strobes", 32'({smp_ack, arg_stb, res_ack, err_stb, fbk_ack, out_stb}), 32'd0);
        checkOutput("reset_data", 32'({arg_dat, out_res}), 32'd0);
        checkOutput("reset_err_fbk", {err_dat, out_fbk}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("smp_ack_pre_edge", 32'(smp_ack), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("smp_ack_first_edge", 32'(smp_ack), 32'd1);

        $display("[TB] learning disabled");
        respRes = 8'hff;
        applyStimulus(16'h07ff, 8'h3c, 1'b0, 0, 0, 1'b0);

        $display("[TB] learning enabled");
        respRes = 8'h80;
        applyStimulus(16'h1234, 8'hc0, 1'b1, 0, 0, 1'b0);
        applyStimulus(16'h4321, 8'h00, 1'b1, 0, 0, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(16'hbeef, 8'h20, 1'b1, 3, 4, 1'b0);

        $display("[TB] reset mid-transaction");
        @(negedge clk);
        smp_stb = 1'b1;
        smp_arg = 16'h4444;
        smp_tgt = 8'h11;
        en      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        smp_stb = 1'b0;
        arg_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arg_ack = 1'b0;
        checkOutput("in_res", 32'(res_ack), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_strobes", 32'({smp_ack, arg_stb, res_ack, err_stb, fbk_ack, out_stb}), 32'd0);
        checkOutput("async_arg_dat", 32'(arg_dat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        respRes = 8'h55;
        applyStimulus(16'h0000, 8'h80, 1'b1, 0, 0, 1'b0);

        $display("[TB] randomized samples");
        for (int k = 0; k < 8; k++) begin
            respRes = 8'($urandom);
            applyStimulus(16'($urandom), 8'($urandom), 1'($urandom % 2),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("[TB] sigmoid integration");
        applyStimulus(16'h0000, 8'h80, 1'b1, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/activation_trainer.md
# activation_trainer

Initiator for the forward/backward strobe-acknowledge protocol spoken by the activation units (`sigmoid` and its siblings). It accepts one training sample (argument plus target) from upstream and drives a forward transaction into the attached activation unit. It then computes the error `target − result` and, when learning is enabled, drives the backward transaction and collects the feedback. Result and feedback are returned upstream as one output beat. The block sits between a sample source or layer controller and one activation instance.

## Interface
Parameters:
- `ARGW`, 16, width of one argument word
- `ARGN`, 1, number of argument words
- `RESW`, 8, result width; unsigned Q0.RESW
- `ERRW`, 16, error width; signed Q(ERRW−RESW).RESW
- `FBKW`, `ARGW*ARGN`, feedback width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  learning enable; sampled at sample accept
- `smp_stb`/`smp_ack`  in/out  1  upstream sample handshake
- `smp_arg`  in  ARGW*ARGN  sample argument
- `smp_tgt`  in  RESW  sample target
- `arg_stb`/`arg_ack`  out/in  1  forward request to activation unit
- `arg_dat`  out  ARGW*ARGN  forward argument
- `res_stb`/`res_ack`  in/out  1  forward result from activation unit
- `res_dat`  in  RESW  result
- `err_stb`/`err_ack`  out/in  1  backward request
- `err_dat`  out  ERRW  error
- `fbk_stb`/`fbk_ack`  in/out  1  backward feedback
- `fbk_dat`  in  FBKW  feedback
- `out_stb`/`out_ack`  out/in  1  upstream result handshake
- `out_res`  out  RESW  captured result
- `out_fbk`  out  FBKW  captured feedback; 0 when not learning

## Operation
- Handshake: a transfer occurs on a rising edge where `stb` and `ack` are both high. The producer holds `stb` and data stable until the transfer.
- FSM states: IDLE, ARG, RES, ERR, FBK, OUT.
  - IDLE: `smp_ack`=1. On `smp_stb`, latch `smp_arg`, `smp_tgt` and `en`, then go to ARG.
  - ARG: `arg_stb`=1 with `arg_dat` = latched argument. On `arg_ack`, go to RES.
  - RES: `res_ack`=1. On `res_stb`, latch `res_dat`. Go to ERR if the latched `en`=1, otherwise to OUT with `out_fbk` cleared to 0.
  - ERR: `err_stb`=1. On `err_ack`, go to FBK.
  - FBK: `fbk_ack`=1. On `fbk_stb`, latch `fbk_dat`, then go to OUT.
  - OUT: `out_stb`=1. On `out_ack`, go to IDLE.
- Error arithmetic: `err_dat` = sign-extend to ERRW of (zero-extended `tgt` − zero-extended `res`), computed at RESW+1 bits. The computation is exact and never saturates. It is registered on the RES→ERR transition.
- Every strobe/ack output is a registered one-hot state flag, so no combinational input→output path exists.
- Changes to `en` after sample accept have no effect on the sample in flight.

## Timing
- Reset: the FSM enters IDLE immediately (asynchronous). All strobe/ack outputs are 0, including `smp_ack`, and all data outputs are 0. `smp_ack` rises on the first clock edge after `rst_n` deasserts.
- Minimum latency: with a sample accepted at edge N and an always-acknowledging partner, `out_stb` rises after edge N+4 when `en`=1, or after edge N+2 when `en`=0.
- Every state lasts at least one cycle. There are no back-to-back bypasses.
- Throughput: at most one sample in flight. `smp_ack` stays low from accept until the `out` transfer completes.
- Backpressure: any state waits indefinitely, with its outputs held stable.
- Reset mid-transaction: the transaction is abandoned. The partner must also be reset, or must tolerate a dropped strobe.

## Structure
- Package `trainer_pkg` holds:
  - the `state_t` enum;
  - default width constants;
  - function `delta(tgt, res)` returning the ERRW error.
- The module is a single FSM with data registers and no sub-module. Instantiating it together with `sigmoid` gives the integration top used by the bench.

## Test plan
- Reset: hold `rst_n` low and check that all outputs are 0. After release, `smp_ack`=1 at the first edge.
- `en`=0, `smp_arg`=16'h07ff, behavioral responder returns `res`=8'hff with zero wait → `out_res`=8'hff, `out_fbk`=0, `err_stb` never asserts, `out_stb` rises at N+2.
- `en`=1, responder `res`=8'h80, feedback = `err`>>>2:
  - `tgt`=8'hc0 → `err_dat`=16'h0040, `out_fbk`=16'h0010.
  - `tgt`=8'h00 → `err_dat`=16'hff80, `out_fbk`=16'hffe0.
- Backpressure: delay `arg_ack` 3 cycles and hold `out_ack` low 4 cycles → `arg_stb`/`arg_dat` and `out_stb`/`out_res` are held stable throughout, and `smp_ack` stays 0 until the out transfer.
- Reset mid-operation: drop `rst_n` while in RES → all strobes go to 0 without waiting for a clock edge. The next sample (`arg` 0, `tgt` 8'h80) completes normally.
- Integration with `sigmoid`: `en`=1, `arg`=16'h0000, `tgt`=8'h80 → `out_res`=8'h80, `err_dat`=16'h0000, `out_fbk`=16'h0000.
